loadable_down_counter: RTL and testbench

//  Loadable down-counter/timer: counterpart to the free-running 3-bit up counter.

---
 rtl/loadable_down_counter_pkg.sv | 19 +
 rtl/downcnt_prescaler.sv | 33 +++
 rtl/loadable_down_counter.sv | 98 +++++++++
 tb/tb_loadable_down_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/loadable_down_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : loadable_down_counter_pkg
//  Purpose : Shared state encoding and default sizing for the counter family.
//  Revision: 1.0  initial release
// ============================================================================
package loadable_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_DEF_WIDTH    = 3;
    localparam int c_DEF_PRESCALE = 4;

endpackage : loadable_down_counter_pkg
`default_nettype wire

// File: rtl/downcnt_prescaler.sv
`default_nettype none
// ============================================================================
//  Module  : downcnt_prescaler
//  Purpose : Emits one tick every PRESCALE enabled cycles; cleared by clr.
//  Revision: 1.0  initial release
// ============================================================================
module downcnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0]   c_LAST = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == c_LAST);

endmodule : downcnt_prescaler
`default_nettype wire

// File: rtl/loadable_down_counter.sv
`default_nettype none
// ============================================================================
//  Module  : loadable_down_counter
//  Purpose : Loadable down-counter/timer, one-shot or auto-reload, with
//            terminal-count strobe. Define DOWNCNT_PRESCALE_EN to insert a
//            PRESCALE-cycle tick prescaler ahead of the decrement.
//  Revision: 1.0  initial release
// ============================================================================
module loadable_down_counter
    import loadable_down_counter_pkg::*;
#(
    parameter int WIDTH    = c_DEF_WIDTH,
    parameter int PRESCALE = c_DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy
);

    state_t           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_count,  w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_tc,     w_tc_nxt;
    logic             w_run_en;
    logic             w_tick;

    assign w_run_en = en && (r_state == RUN);

`ifdef DOWNCNT_PRESCALE_EN
    downcnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (w_run_en),
        .tick  (w_tick)
    );
`else
    // Without the prescaler every enabled RUN cycle is a tick; PRESCALE only
    // gates the tick through its own legality so the parameter stays live.
    localparam bit c_PRESCALE_OK = (PRESCALE >= 1);
    assign w_tick = w_run_en && c_PRESCALE_OK;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = (load_val != '0) ? RUN : IDLE;
        end else if (w_tick) begin
            if (r_count > WIDTH'(1)) begin
                w_count_nxt = r_count - 1'b1;
            end else begin
                // Terminal decrement: auto_reload is only looked at here.
                w_tc_nxt = 1'b1;
                if (auto_reload) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = DONE;
                end
            end
        end
    end

    assign count    = r_count;
    assign zero     = (r_count == '0);
    assign tc_pulse = r_tc;
    assign busy     = (r_state == RUN);

endmodule : loadable_down_counter
`default_nettype wire

// File: tb/tb_loadable_down_counter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_loadable_down_counter
//  Purpose : Self-checking bench: directed literal sequences plus random
//            stimulus compared every cycle against a behavioural model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_loadable_down_counter;

    localparam int WIDTH    = 3;
    localparam int PRESCALE = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             en = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc_pulse;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    // behavioural model
    int m_count  = 0;
    int m_reload = 0;
    bit m_run    = 1'b0;
    bit m_tc     = 1'b0;
    int m_pre    = 0;

    loadable_down_counter #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .tc_pulse    (tc_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a timer that runs while it holds a nonzero value; each tick
    // lowers it, and hitting zero either refills it or stops it.
    always @(posedge clk) begin
        bit tick;
        if (reset) begin
            m_count = 0; m_reload = 0; m_run = 0; m_tc = 0; m_pre = 0;
        end else if (load) begin
            m_count = int'(load_val); m_reload = int'(load_val);
            m_run = (load_val != 0); m_tc = 0; m_pre = 0;
        end else begin
            m_tc = 0;
            if (m_run && en) begin
`ifdef DOWNCNT_PRESCALE_EN
                m_pre = m_pre + 1;
                tick  = (m_pre == PRESCALE);
                if (tick) m_pre = 0;
`else
                tick = 1'b1;
`endif
                if (tick) begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin
                        m_tc = 1;
                        if (auto_reload) m_count = m_reload;
                        else m_run = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_count", int'(count), m_count);
            chk("model_zero", int'(zero), int'(m_count == 0));
            chk("model_tc", int'(tc_pulse), int'(m_tc));
            chk("model_busy", int'(busy), int'(m_run));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int c, input int tc);
        chk({name, "_count"}, int'(count), c);
        chk({name, "_tc"}, int'(tc_pulse), tc);
    endtask

    initial begin
        reset = 1'b1;
        cyc(); cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tc", int'(tc_pulse), 0);
        reset = 1'b0; en = 1'b1;
        checking = 1'b1;
        cyc(); cyc();
        lit("idle_en", 0, 0);

`ifndef DOWNCNT_PRESCALE_EN
        // one-shot from 5
        load = 1; load_val = 3'd5; auto_reload = 0; cyc(); load = 0;
        lit("os_load", 5, 0);
        for (int v = 4; v >= 0; v--) begin
            cyc(); lit("os_dec", v, int'(v == 0));
        end
        for (int i = 0; i < 5; i++) begin
            cyc(); lit("os_done", 0, 0);
            chk("os_done_busy", int'(busy), 0);
        end
        // auto-reload from 3
        load = 1; load_val = 3'd3; auto_reload = 1; cyc(); load = 0;
        lit("ar_load", 3, 0);
        for (int i = 0; i < 6; i++) begin
            int e;
            e = 2 - (i % 3);
            if (e == 0) e = 3;
            cyc(); lit("ar_seq", e, int'(e == 3));
        end
        auto_reload = 0;
        cyc(); lit("ar_stop", 2, 0);
        cyc(); lit("ar_stop", 1, 0);
        cyc(); lit("ar_stop", 0, 1);
        chk("ar_stop_busy", int'(busy), 0);
        // hold with en low, reload mid-count, load zero
        load = 1; load_val = 3'd7; en = 0; cyc(); load = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); lit("hold", 7, 0);
        end
        en = 1;
        for (int v = 6; v >= 2; v--) begin
            cyc(); lit("run7", v, 0);
        end
        load = 1; load_val = 3'd4; cyc();
        lit("reload4", 4, 0);
        load_val = 3'd0; cyc(); load = 0;
        lit("load0", 0, 0);
        chk("load0_zero", int'(zero), 1);
        chk("load0_busy", int'(busy), 0);
        // reset mid-count
        load = 1; load_val = 3'd7; cyc(); load = 0;
        for (int v = 6; v >= 3; v--) begin
            cyc(); lit("pre_rst", v, 0);
        end
        reset = 1; cyc(); reset = 0;
        lit("mid_rst", 0, 0);
        chk("mid_rst_busy", int'(busy), 0);
`else
        load = 1; load_val = 3'd2; auto_reload = 0; cyc(); load = 0;
        lit("ps_load", 2, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(); lit("ps_run", (k < 4) ? 2 : ((k < 8) ? 1 : 0), int'(k == 8));
        end
        load = 1; load_val = 3'd1; cyc(); load = 0;
        cyc(); cyc();
        en = 0; cyc(); cyc(); cyc();
        lit("ps_gap", 1, 0);
        en = 1; cyc(); lit("ps_gap3", 1, 0);
        cyc(); lit("ps_gap4", 0, 1);
`endif

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            load        = ($urandom_range(0, 7) == 0);
            load_val    = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            en          = ($urandom_range(0, 3) != 0);
            auto_reload = $urandom_range(0, 1) == 1;
            cyc();
        end
        reset = 0; load = 0;
        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_loadable_down_counter
`default_nettype wire
